// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register: load/shift/rotate applied AMT times under a START/BUSY/DONE handshake.
// Optional macro USR_PARITY_EN adds output PAR = XOR-reduction of S.
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] X,
    input  logic [2:0]       M,
    input  logic [AMT_W-1:0] AMT,
    input  logic             START,
    input  logic             SIN,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             BUSY,
`ifdef USR_PARITY_EN
    output logic             PAR,
`endif
    output logic             DONE
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_SER  = 3'b111;

    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH:0]   step_res;

    // One 1-bit step; result is {carry_out, new_word}.
    function automatic logic [WIDTH:0] step_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] s,
        input logic             sin
    );
        logic [WIDTH:0] r;
        r = {1'b0, s};
        case (op)
            OP_SHL:  r = {s[WIDTH-1], s[WIDTH-2:0], 1'b0};
            OP_SHR:  r = {s[0], 1'b0, s[WIDTH-1:1]};
            OP_ROL:  r = {s[WIDTH-1], s[WIDTH-2:0], s[WIDTH-1]};
            OP_ROR:  r = {s[0], s[0], s[WIDTH-1:1]};
            OP_ASR:  r = {s[0], s[WIDTH-1], s[WIDTH-1:1]};
            OP_SER:  r = {s[0], sin, s[WIDTH-1:1]};
            default: r = {1'b0, s};
        endcase
        return r;
    endfunction

    assign step_res = step_op(op_q, s_q, SIN);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    // Hold, load and zero-length requests finish on the accepting edge.
                    if (M == OP_HOLD || M == OP_LOAD || AMT == '0) begin
                        if (M == OP_LOAD) begin
                            s_d = X;
                        end
                        done_d = 1'b1;
                    end else begin
                        op_d    = M;
                        cnt_d   = AMT;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                s_d    = step_res[WIDTH-1:0];
                cout_d = step_res[WIDTH];
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= OP_HOLD;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign S    = s_q;
    assign COUT = cout_q;
    assign BUSY = (state_q == ST_RUN);
    assign DONE = done_q;

`ifdef USR_PARITY_EN
    assign PAR = ^s_q;
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg (WIDTH=8, AMT_W=4).
// Define USR_PARITY_EN on both files to also exercise the PAR output.
module tb_universal_shift_reg;

    logic       CLK;
    logic       RST;
    logic [7:0] X;
    logic [2:0] M;
    logic [3:0] AMT;
    logic       START;
    logic       SIN;
    logic [7:0] S;
    logic       COUT;
    logic       BUSY;
    logic       DONE;
`ifdef USR_PARITY_EN
    logic       PAR;
`endif

    int n_checks = 0;
    int n_errors = 0;

    universal_shift_reg #(.WIDTH(8), .AMT_W(4)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .X    (X),
        .M    (M),
        .AMT  (AMT),
        .START(START),
        .SIN  (SIN),
        .S    (S),
        .COUT (COUT),
        .BUSY (BUSY),
`ifdef USR_PARITY_EN
        .PAR  (PAR),
`endif
        .DONE (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [7:0] x);
        M = 3'b001; X = x; AMT = 4'd0; START = 1'b1;
        tick();
        START = 1'b0;
        check("load_s", S, x);
        check("load_done", DONE, 1);
        check("load_busy", BUSY, 0);
        tick();
        check("load_done_clr", DONE, 0);
    endtask

    // Issue an op, wait (bounded) for DONE, verify latency, result and carry.
    task automatic run_op(input string tag, input logic [2:0] m, input logic [3:0] amt,
                          input logic [7:0] exp_s, input logic exp_cout, input logic poke);
        int cycles;
        int exp_cycles;
        M = m; AMT = amt; START = 1'b1;
        tick();
        START = 1'b0;
        cycles = 1;
        exp_cycles = (m == 3'b000 || m == 3'b001 || amt == 4'd0) ? 1 : int'(amt) + 1;
        while (!DONE && cycles < 40) begin
            check({tag, "_busy"}, BUSY, 1);
            if (poke && cycles == 1) begin
                START = 1'b1; M = 3'b001; X = 8'hFF; AMT = 4'hF;
            end else begin
                START = 1'b0;
            end
            tick();
            cycles++;
        end
        START = 1'b0;
        check({tag, "_done"}, DONE, 1);
        check({tag, "_latency"}, cycles, exp_cycles);
        check({tag, "_busy_end"}, BUSY, 0);
        check({tag, "_s"}, S, exp_s);
        check({tag, "_cout"}, COUT, exp_cout);
        tick();
        check({tag, "_done_pulse"}, DONE, 0);
        check({tag, "_s_hold"}, S, exp_s);
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; X = 8'h00; M = 3'b000; AMT = 4'd0; SIN = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        check("rst_s", S, 8'h00);
        check("rst_cout", COUT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
`ifdef USR_PARITY_EN
        check("rst_par", PAR, 0);
`endif

        load(8'h54);

        // SHL by 3, checked step by step
        M = 3'b010; AMT = 4'd3; START = 1'b1;
        tick();
        START = 1'b0;
        check("shl_s0", S, 8'h54);
        check("shl_busy0", BUSY, 1);
        tick();
        check("shl_s1", S, 8'hA8);
        check("shl_busy1", BUSY, 1);
        check("shl_done1", DONE, 0);
        tick();
        check("shl_s2", S, 8'h50);
        check("shl_busy2", BUSY, 1);
        tick();
        check("shl_s3", S, 8'hA0);
        check("shl_done3", DONE, 1);
        check("shl_busy3", BUSY, 0);
        check("shl_cout", COUT, 0);
        tick();
        check("shl_done_clr", DONE, 0);

        load(8'hAB);
        run_op("asr", 3'b110, 4'd2, 8'hEA, 1'b1, 1'b1);

        load(8'hAB);
        run_op("ror9", 3'b101, 4'd9, 8'hD5, 1'b1, 1'b0);
        run_op("amt0", 3'b101, 4'd0, 8'hD5, 1'b1, 1'b0);

        load(8'h54);
        run_op("shr", 3'b011, 4'd3, 8'h0A, 1'b1, 1'b0);

        load(8'h81);
        run_op("rol", 3'b100, 4'd1, 8'h03, 1'b1, 1'b0);

        load(8'h00);
        SIN = 1'b1;
        run_op("ser", 3'b111, 4'd3, 8'hE0, 1'b0, 1'b0);
        SIN = 1'b0;
        run_op("hold", 3'b000, 4'd5, 8'hE0, 1'b0, 1'b0);

        // START reasserted in the DONE cycle is accepted
        M = 3'b001; X = 8'h11; START = 1'b1;
        tick();
        check("b2b_s1", S, 8'h11);
        check("b2b_done1", DONE, 1);
        X = 8'h22;
        tick();
        START = 1'b0;
        check("b2b_s2", S, 8'h22);
        check("b2b_done2", DONE, 1);
        tick();
        check("b2b_done_clr", DONE, 0);

        // Reset in the middle of a run aborts without DONE
        load(8'h54);
        M = 3'b011; AMT = 4'd3; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        check("abort_s1", S, 8'h2A);
        check("abort_busy1", BUSY, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort_s", S, 8'h00);
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        check("abort_cout", COUT, 0);
        tick();
        check("abort_nodone", DONE, 0);
        check("abort_s_after", S, 8'h00);

`ifdef USR_PARITY_EN
        load(8'h54);
        check("par_54", PAR, 1);
        load(8'hAB);
        check("par_ab", PAR, 1);
        load(8'h03);
        check("par_03", PAR, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
